// File: rtl/qram_access_scheduler_pkg.sv
// Shared encodings for the QRAM access scheduler: array command codes,
// scheduler FSM states and a small helper for sizing the timing counter.
package qram_access_scheduler_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACT_WAIT,
    ST_ACCESS,
    ST_RD_WAIT,
    ST_PRE_WAIT,
    ST_REF_WAIT
  } state_e;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/qram_access_scheduler_if.sv
// Requester handshake plus QRAM pin bundle; master is the environment
// (requesters and array), slave is the scheduler.
interface qram_access_scheduler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [2:0]          q_cmd;
  logic [ADDR_W-1:0]   q_addr;
  logic [DATA_W-1:0]   q_wdata;
  logic                q_wr_en;
  logic [DATA_W-1:0]   q_rdata;
  logic                busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, q_rdata,
    input  req_ready, rsp_valid, rsp_rdata, q_cmd, q_addr, q_wdata, q_wr_en, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, q_rdata,
    output req_ready, rsp_valid, rsp_rdata, q_cmd, q_addr, q_wdata, q_wr_en, busy
  );

endinterface

// File: rtl/qram_access_scheduler_refresh_timer.sv
// Free-running refresh interval timer with a sticky refresh-due flag that
// is cleared when the scheduler issues REF.
module qram_access_scheduler_refresh_timer #(
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic clk,
  input  logic srst,
  input  logic refresh_taken,
  output logic refresh_due
);

  localparam int TMR_W = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [TMR_W-1:0] RELOAD  = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  logic [TMR_W-1:0] timer_reg;
  logic             due_reg;

  // A new due event wins over a same-cycle take so no interval is lost.
  always_ff @(posedge clk) begin
    if (srst) begin
      timer_reg <= RELOAD;
      due_reg   <= 1'b0;
    end else begin
      if (timer_reg == '0) begin
        timer_reg <= RELOAD;
        due_reg   <= 1'b1;
      end else begin
        timer_reg <= timer_reg - TMR_ONE;
        if (refresh_taken) due_reg <= 1'b0;
      end
    end
  end

  assign refresh_due = due_reg;

endmodule

// File: rtl/qram_access_scheduler.sv
// Two-requester round-robin scheduler that owns the QRAM pins and sequences
// each access as ACT -> RD/WR -> PRE, with periodic REF taking priority.
module qram_access_scheduler
  import qram_access_scheduler_pkg::*;
#(
  parameter int ADDR_W           = 8,
  parameter int DATA_W           = 8,
  parameter int T_RCD            = 2,
  parameter int CAS_LAT          = 2,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 4,
  parameter int REFRESH_INTERVAL = 64
) (
  input logic                   clk,
  input logic                   srst,
  qram_access_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(max_of4(T_RCD, CAS_LAT, T_RP, T_RFC) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] CAS_LOAD = CNT_W'(CAS_LAT);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);

  state_e              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                last_grant_reg;
  logic                grant_reg;
  logic                wr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;

  logic [1:0]          req_ready_reg;
  logic [1:0]          rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic [2:0]          q_cmd_reg;
  logic [ADDR_W-1:0]   q_addr_reg;
  logic [DATA_W-1:0]   q_wdata_reg;
  logic                q_wr_en_reg;
  logic                busy_reg;

  logic                refresh_due;
  logic                refresh_taken;
  logic                grant_sel;
  logic [ADDR_W-1:0]   req_addr_arr  [2];
  logic [DATA_W-1:0]   req_wdata_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign req_addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign req_wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    grant_sel = 1'b0;
    case (bus.req_valid)
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant_reg;
      default: grant_sel = 1'b0;
    endcase
  end

  assign refresh_taken = (state_reg == ST_IDLE) && refresh_due;

  qram_access_scheduler_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk          (clk),
    .srst         (srst),
    .refresh_taken(refresh_taken),
    .refresh_due  (refresh_due)
  );

  // Every pin output is a pulse or a per-command value, so all default to 0
  // each cycle and only the active state drives them.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;  // first contested grant goes to req0
      grant_reg      <= 1'b0;
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_rdata_reg  <= '0;
      q_cmd_reg      <= CMD_NOP;
      q_addr_reg     <= '0;
      q_wdata_reg    <= '0;
      q_wr_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      req_ready_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      q_cmd_reg     <= CMD_NOP;
      q_addr_reg    <= '0;
      q_wdata_reg   <= '0;
      q_wr_en_reg   <= 1'b0;
      busy_reg      <= (state_reg != ST_IDLE);

      case (state_reg)
        ST_IDLE: begin
          if (refresh_due) begin
            q_cmd_reg <= CMD_REF;
            cnt_reg   <= RFC_LOAD;
            state_reg <= (RFC_LOAD == '0) ? ST_IDLE : ST_REF_WAIT;
          end else if (bus.req_valid != 2'b00) begin
            req_ready_reg  <= grant_sel ? 2'b10 : 2'b01;
            grant_reg      <= grant_sel;
            last_grant_reg <= grant_sel;
            wr_reg         <= bus.req_write[grant_sel];
            addr_reg       <= req_addr_arr[grant_sel];
            wdata_reg      <= req_wdata_arr[grant_sel];
            q_cmd_reg      <= CMD_ACT;
            q_addr_reg     <= req_addr_arr[grant_sel];
            cnt_reg        <= RCD_LOAD;
            state_reg      <= (RCD_LOAD == '0) ? ST_ACCESS : ST_ACT_WAIT;
          end
        end
        ST_ACT_WAIT: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg <= CNT_ONE) state_reg <= ST_ACCESS;
        end
        ST_ACCESS: begin
          q_addr_reg <= addr_reg;
          state_reg  <= ST_RD_WAIT;
          if (wr_reg) begin
            // A write completes the cycle after WR, so it reuses RD_WAIT at zero.
            q_cmd_reg   <= CMD_WR;
            q_wr_en_reg <= 1'b1;
            q_wdata_reg <= wdata_reg;
            cnt_reg     <= '0;
          end else begin
            q_cmd_reg <= CMD_RD;
            cnt_reg   <= CAS_LOAD;
          end
        end
        ST_RD_WAIT: begin
          if (cnt_reg == '0) begin
            rsp_valid_reg <= grant_reg ? 2'b10 : 2'b01;
            if (!wr_reg) rsp_rdata_reg <= bus.q_rdata;
            q_cmd_reg <= CMD_PRE;
            cnt_reg   <= RP_LOAD;
            state_reg <= (RP_LOAD == '0) ? ST_IDLE : ST_PRE_WAIT;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        ST_PRE_WAIT, ST_REF_WAIT: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg <= CNT_ONE) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.q_cmd     = q_cmd_reg;
  assign bus.q_addr    = q_addr_reg;
  assign bus.q_wdata   = q_wdata_reg;
  assign bus.q_wr_en   = q_wr_en_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_qram_access_scheduler.sv
// Directed bench for qram_access_scheduler: reads, writes, round-robin,
// refresh interplay and mid-access reset, checked against hand-derived cycles.
module tb_qram_access_scheduler;
  import qram_access_scheduler_pkg::*;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int ref_count = 0;

  always #5 clk = ~clk;

  qram_access_scheduler_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  qram_access_scheduler dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.q_cmd == CMD_REF) ref_count++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    bus.req_valid = 2'b00;
    step();
    srst      = 1'b0;
    cyc       = 0;
    ref_count = 0;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    bus.req_valid[r]         = 1'b1;
    bus.req_write[r]         = wr;
    bus.req_addr[r*8 +: 8]   = addr;
    bus.req_wdata[r*8 +: 8]  = data;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.q_rdata   = '0;

    // Reset state
    do_reset();
    check("rst_cmd",   bus.q_cmd,     CMD_NOP);
    check("rst_addr",  bus.q_addr,    0);
    check("rst_wdata", bus.q_wdata,   0);
    check("rst_wren",  bus.q_wr_en,   0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp",   bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_busy",  bus.busy,      0);

    // Test 1: read req0 @0x12, array returns 0xA5 CAS_LAT after RD
    $display("T1 read req0 addr 0x12");
    bus.q_rdata = 8'hFF;
    set_req(0, 1'b0, 8'h12, 8'h00);
    step();
    check("t1_act",   bus.q_cmd,     CMD_ACT);
    check("t1_aaddr", bus.q_addr,    8'h12);
    check("t1_ready", bus.req_ready, 2'b01);
    check("t1_busy0", bus.busy,      0);
    bus.req_valid = 2'b00;
    step();
    check("t1_nop1",  bus.q_cmd,     CMD_NOP);
    check("t1_busy1", bus.busy,      1);
    step();
    check("t1_rd",    bus.q_cmd,     CMD_RD);
    check("t1_raddr", bus.q_addr,    8'h12);
    step();
    check("t1_nop3",  bus.q_cmd,     CMD_NOP);
    step();
    check("t1_nop4",  bus.q_cmd,     CMD_NOP);
    bus.q_rdata = 8'hA5;
    step();
    check("t1_rsp",   bus.rsp_valid, 2'b01);
    check("t1_rdata", bus.rsp_rdata, 8'hA5);
    check("t1_pre",   bus.q_cmd,     CMD_PRE);
    check("t1_paddr", bus.q_addr,    0);
    bus.q_rdata = 8'h00;
    step();
    check("t1_rsp6",  bus.rsp_valid, 0);
    check("t1_busy6", bus.busy,      1);
    step();
    check("t1_busy7", bus.busy,      0);

    // Test 2: write req1 @0x34 data 0x5A, then next ACT at PRE+T_RP
    $display("T2 write req1 addr 0x34 data 0x5A");
    do_reset();
    set_req(1, 1'b1, 8'h34, 8'h5A);
    step();
    check("t2_act",   bus.q_cmd,     CMD_ACT);
    check("t2_aaddr", bus.q_addr,    8'h34);
    check("t2_ready", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    step();
    check("t2_nop1",  bus.q_cmd,     CMD_NOP);
    step();
    check("t2_wr",    bus.q_cmd,     CMD_WR);
    check("t2_wren",  bus.q_wr_en,   1);
    check("t2_wdata", bus.q_wdata,   8'h5A);
    check("t2_waddr", bus.q_addr,    8'h34);
    step();
    check("t2_rsp",   bus.rsp_valid, 2'b10);
    check("t2_pre",   bus.q_cmd,     CMD_PRE);
    check("t2_wren3", bus.q_wr_en,   0);
    set_req(0, 1'b0, 8'h01, 8'h00);
    step();
    check("t2_wait",  bus.q_cmd,     CMD_NOP);
    check("t2_rdy4",  bus.req_ready, 0);
    step();
    check("t2_act2",  bus.q_cmd,     CMD_ACT);
    check("t2_rdy5",  bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;

    // Test 3: both requesters hold writes; grants alternate 0,1,0,1 every 5 cycles
    $display("T3 round-robin with both requesters held");
    do_reset();
    set_req(0, 1'b1, 8'h10, 8'hA0);
    set_req(1, 1'b1, 8'h20, 8'hB1);
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] g_exp;
      step();
      g_exp = (((k - 1) / 5) % 2 == 0) ? 2'b01 : 2'b10;
      check("t3_ready", bus.req_ready, ((k - 1) % 5 == 0) ? g_exp : 2'b00);
      check("t3_rsp",   bus.rsp_valid, ((k - 1) % 5 == 3) ? g_exp : 2'b00);
      if ((k - 1) % 5 == 2)
        check("t3_wdata", bus.q_wdata, (g_exp == 2'b01) ? 8'hA0 : 8'hB1);
    end
    bus.req_valid = 2'b00;

    // Test 4: refresh becomes due (cycle 64) while a read is in flight
    $display("T4 refresh due during read");
    do_reset();
    bus.q_rdata = 8'hC3;
    repeat (59) step();
    set_req(0, 1'b0, 8'h40, 8'h00);
    step();
    check("t4_act",   bus.q_cmd,     CMD_ACT);
    check("t4_rdy",   bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    step();
    set_req(1, 1'b0, 8'h41, 8'h00);
    repeat (4) step();
    check("t4_rsp",   bus.rsp_valid, 2'b01);
    check("t4_rdata", bus.rsp_rdata, 8'hC3);
    check("t4_pre",   bus.q_cmd,     CMD_PRE);
    step();
    check("t4_nop66", bus.q_cmd,     CMD_NOP);
    step();
    check("t4_ref",   bus.q_cmd,     CMD_REF);
    check("t4_rdy67", bus.req_ready, 0);
    repeat (3) step();
    check("t4_nop70", bus.q_cmd,     CMD_NOP);
    check("t4_rdy70", bus.req_ready, 0);
    step();
    check("t4_act2",  bus.q_cmd,     CMD_ACT);
    check("t4_aaddr", bus.q_addr,    8'h41);
    check("t4_rdy71", bus.req_ready, 2'b10);
    bus.req_valid = 2'b00;
    while (cyc < 200) step();
    check("t4_refcnt", ref_count,    3);

    // Test 5: reset on the RD cycle drops the access
    $display("T5 reset during read");
    do_reset();
    bus.q_rdata = 8'h9E;
    set_req(0, 1'b0, 8'h77, 8'h00);
    step();
    check("t5_act",   bus.q_cmd,     CMD_ACT);
    bus.req_valid = 2'b00;
    step();
    step();
    check("t5_rd",    bus.q_cmd,     CMD_RD);
    srst = 1'b1;
    step();
    check("t5_cmd",   bus.q_cmd,     CMD_NOP);
    check("t5_addr",  bus.q_addr,    0);
    check("t5_rsp",   bus.rsp_valid, 0);
    check("t5_rdata", bus.rsp_rdata, 0);
    check("t5_busy",  bus.busy,      0);
    srst = 1'b0;
    set_req(0, 1'b0, 8'h21, 8'h00);
    step();
    check("t5_act2",  bus.q_cmd,     CMD_ACT);
    check("t5_aaddr", bus.q_addr,    8'h21);
    check("t5_rdy",   bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    repeat (4) begin
      step();
      check("t5_norsp", bus.rsp_valid, 0);
    end
    step();
    check("t5_rsp2",   bus.rsp_valid, 2'b01);
    check("t5_rdata2", bus.rsp_rdata, 8'h9E);

    // Test 6: refresh due and request arrive together in IDLE
    $display("T6 refresh vs request in idle");
    do_reset();
    repeat (64) step();
    set_req(0, 1'b0, 8'h55, 8'h00);
    step();
    check("t6_ref",   bus.q_cmd,     CMD_REF);
    check("t6_rdy0",  bus.req_ready, 0);
    repeat (3) step();
    check("t6_nop",   bus.q_cmd,     CMD_NOP);
    check("t6_rdy3",  bus.req_ready, 0);
    step();
    check("t6_act",   bus.q_cmd,     CMD_ACT);
    check("t6_aaddr", bus.q_addr,    8'h55);
    check("t6_rdy",   bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
